// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector: freezes PC and IF/ID and bubbles ID/EX for STALL_CYCLES
// cycles when the ID instruction reads the register a load in EX is writing.
module load_use_hazard_unit #(
  parameter int                      REG_ADDR_W   = 3,
  parameter int                      OPCODE_W     = 5,
  parameter logic [OPCODE_W-1:0]     LOAD_OPC_A   = 5'b10010,
  parameter logic [OPCODE_W-1:0]     LOAD_OPC_B   = 5'b10000,
  parameter int                      STALL_CYCLES = 1,
  parameter int                      CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard_en,
  input  logic                  ex_valid,
  input  logic [OPCODE_W-1:0]   ex_opcode,
  input  logic [REG_ADDR_W-1:0] ex_rdst,
  input  logic                  id_valid,
  input  logic                  id_uses_rsrc,
  input  logic                  id_uses_rdst,
  input  logic [REG_ADDR_W-1:0] id_rsrc,
  input  logic [REG_ADDR_W-1:0] id_rdst,
  input  logic                  flush,
  input  logic                  cnt_clear,
  output logic                  freeze_pc,
  output logic                  freeze_ifid,
  output logic                  bubble_idex,
  output logic                  stall_busy,
  output logic [CNT_W-1:0]      hazard_count
);

  typedef enum logic {IDLE, STALL} state_t;

  // The first stall cycle is spent in IDLE, so STALL covers the remaining ones.
  localparam logic [1:0] REM_INIT = (STALL_CYCLES > 1) ? 2'(STALL_CYCLES - 2) : 2'd0;
  localparam bit         USE_STALL_STATE = (STALL_CYCLES > 1);

  state_t     state, state_nxt;
  logic [1:0] rem, rem_nxt;
  logic       is_load;
  logic       reg_match;
  logic       hit;
  logic       stall;
  logic       cnt_inc;

  assign is_load   = (ex_opcode == LOAD_OPC_A) || (ex_opcode == LOAD_OPC_B);
  assign reg_match = (id_uses_rsrc && (id_rsrc == ex_rdst)) ||
                     (id_uses_rdst && (id_rdst == ex_rdst));
  assign hit       = hazard_en && ex_valid && id_valid && is_load && reg_match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rem   <= 2'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Flush wins over everything; STALL ignores hit so a hazard is counted only once.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    stall     = 1'b0;
    cnt_inc   = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      rem_nxt   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            stall   = 1'b1;
            cnt_inc = 1'b1;
            if (USE_STALL_STATE) begin
              state_nxt = STALL;
              rem_nxt   = REM_INIT;
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          if (rem == 2'd0) begin
            state_nxt = IDLE;
          end else begin
            rem_nxt = rem - 2'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          rem_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Gate with reset so a live hit cannot freeze the pipe while reset is held.
  assign freeze_pc   = stall && rst;
  assign freeze_ifid = stall && rst;
  assign bubble_idex = stall && rst;
  assign stall_busy  = (state == STALL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hazard_count <= '0;
    end else if (cnt_clear) begin
      hazard_count <= '0;
    end else if (cnt_inc && (hazard_count != {CNT_W{1'b1}})) begin
      hazard_count <= hazard_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/load_use_hazard_unit.md
LOAD_USE_HAZARD_UNIT -- requirements
Module: load_use_hazard_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 3, SHALL set the register-address width.
REQ-002 Parameter OPCODE_W, default 5, SHALL set the opcode width.
REQ-003 Parameter LOAD_OPC_A, default 5'b10010 (LDD), SHALL be a load-class opcode.
REQ-004 Parameter LOAD_OPC_B, default 5'b10000 (POP), SHALL be a load-class opcode.
REQ-005 Parameter STALL_CYCLES, default 1, legal range 1..4, SHALL set the bubbles inserted per hazard.
REQ-006 Parameter CNT_W, default 16, SHALL set the hazard-counter width.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 hazard_en  in  1  1 = detection enabled; 0 = detection suppressed.
REQ-010 ex_valid  in  1  the EX-stage instruction is valid.
REQ-011 ex_opcode  in  OPCODE_W  opcode of the instruction in EX.
REQ-012 ex_rdst  in  REG_ADDR_W  destination register of the EX instruction.
REQ-013 id_valid  in  1  the ID-stage instruction is valid.
REQ-014 id_uses_rsrc, id_uses_rdst  in  1 each  the ID instruction reads Rsrc / Rdst.
REQ-015 id_rsrc, id_rdst  in  REG_ADDR_W each  ID source / destination register addresses.
REQ-016 flush  in  1  branch/interrupt flush; aborts any stall.
REQ-017 cnt_clear  in  1  synchronous clear of hazard_count.
REQ-018 freeze_pc  out  1  hold the PC.
REQ-019 freeze_ifid  out  1  hold the IF/ID register.
REQ-020 bubble_idex  out  1  load a NOP into ID/EX.
REQ-021 stall_busy  out  1  FSM is in STALL.
REQ-022 hazard_count  out  CNT_W  number of hazards detected, saturating.

Function
REQ-023 hit SHALL be: hazard_en & ex_valid & id_valid & (ex_opcode==LOAD_OPC_A | ex_opcode==LOAD_OPC_B) & ((id_uses_rsrc & id_rsrc==ex_rdst) | (id_uses_rdst & id_rdst==ex_rdst)).
REQ-024 The FSM SHALL have exactly two states, IDLE and STALL, plus a remaining-cycle counter rem (width 2).
REQ-025 In IDLE with hit=1 and flush=0: freeze_pc, freeze_ifid and bubble_idex SHALL be 1 combinationally in the same cycle (zero latency).
REQ-026 On the same edge, hazard_count SHALL increment unless it is all-ones.
REQ-027 On the same edge, if STALL_CYCLES>1 the FSM SHALL go to STALL with rem=STALL_CYCLES-2; otherwise it SHALL stay in IDLE.
REQ-028 In STALL, all three freeze/bubble outputs SHALL be 1 and hit SHALL be ignored; there is no re-detection and no count.
REQ-029 In STALL with rem==0 the FSM SHALL return to IDLE at the next edge; otherwise rem SHALL decrement.
REQ-030 Total consecutive cycles with freeze_pc=1 per hazard SHALL equal STALL_CYCLES exactly.
REQ-031 flush=1 in any state SHALL force all freeze/bubble outputs to 0 that cycle and move the FSM to IDLE with rem=0 at the next edge.
REQ-032 A hit coincident with flush SHALL NOT be counted.
REQ-033 hazard_en=0 SHALL suppress new detection only; a stall already in progress SHALL complete.
REQ-034 cnt_clear=1 SHALL set hazard_count to 0 at the next edge.
REQ-035 cnt_clear SHALL take priority over a coincident increment.
REQ-036 stall_busy SHALL equal (state==STALL).
REQ-037 ex_valid=0 or id_valid=0 SHALL never produce a hazard.
REQ-038 An ID instruction that reads no register SHALL never produce a hazard.

Reset
REQ-039 rst=0 SHALL asynchronously force state=IDLE, rem=0, hazard_count=0, and freeze_pc=freeze_ifid=bubble_idex=stall_busy=0.
REQ-040 Reset asserted mid-stall SHALL abort the stall immediately.
REQ-041 After rst deasserts, detection SHALL resume on the first rising edge.

Verification
REQ-042 STALL_CYCLES=1: ex_opcode=10010, ex_rdst=3, id_rsrc=3 with uses_rsrc=1, all valid -> freeze_pc=1 for exactly 1 cycle; hazard_count 0->1; stall_busy stays 0.
REQ-043 STALL_CYCLES=3, POP with ex_rdst=5, id_rdst=5 with uses_rdst=1 -> freeze_pc and bubble_idex=1 for 3 consecutive cycles; stall_busy=1 in cycles 2-3.
REQ-044 STALL_CYCLES=3, flush in the 2nd stall cycle -> outputs 0 that cycle and state=IDLE next cycle; count=1.
REQ-045 Non-load opcode 00001 with matching rdst, or id_uses_rsrc=0, or hazard_en=0 -> no freeze; count unchanged.
REQ-046 CNT_W=2 with 4 back-to-back hazards -> count saturates at 3; cnt_clear together with a hit -> count 0.
REQ-047 rst pulsed low mid-stall, asynchronously to clk -> all outputs 0 immediately; count 0.
